// File: rtl/execute_stage_md.sv
// rtl/execute_stage_md.sv - RV32IM execute stage with forwarding, branch/JALR resolution,
// iterative mul/div unit and EX/MEM pipeline register.
module execute_stage_md #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [4:0]      RdE,
  input  logic [2:0]      Funct3E,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            MulDivE,
  input  logic [1:0]      ResultSrcE,
  input  logic [3:0]      ALUControlE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic            RegWriteM,
  output logic [XLEN-1:0] PCTargetE,
  output logic            PCSrcE,
  output logic            StallE
);

  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  logic [XLEN-1:0] src_a, src_b, write_data, alu_y, md_y, alu_result, jalr_sum;
  logic [SH_W-1:0] shamt;
  logic            taken;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = ALUResultM;
      default: write_data = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : write_data;
  end

  assign shamt = src_b[SH_W-1:0];

  always_comb begin
    alu_y = '0;
    case (ALUControlE)
      4'b0000: alu_y = src_a + src_b;
      4'b0001: alu_y = src_a - src_b;
      4'b0010: alu_y = src_a & src_b;
      4'b0011: alu_y = src_a | src_b;
      4'b0100: alu_y = src_a ^ src_b;
      4'b0101: alu_y = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: alu_y = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'b0111: alu_y = src_a << shamt;
      4'b1000: alu_y = src_a >> shamt;
      4'b1001: alu_y = $signed(src_a) >>> shamt;
      4'b1010: alu_y = src_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (Funct3E)
      3'b000:  taken = (src_a == write_data);
      3'b001:  taken = (src_a != write_data);
      3'b100:  taken = ($signed(src_a) < $signed(write_data));
      3'b101:  taken = ($signed(src_a) >= $signed(write_data));
      3'b110:  taken = (src_a < write_data);
      3'b111:  taken = (src_a >= write_data);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a + ImmExtE;
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : PCE + ImmExtE;
  assign PCSrcE    = (JumpE | (BranchE & taken)) & ~StallE;

  // Mul/div unit: operands are reduced to magnitudes on entry and the sign is re-applied at DONE.
  md_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod_s;
  logic [XLEN-1:0]   opnd, dvd_q, a_mag, b_mag, dr, dr_s;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2:0]        op_q;
  logic              neg_q, div0_q, is_div, a_sgn, b_sgn, a_neg, b_neg;

  always_comb begin
    is_div = Funct3E[2];
    a_sgn  = is_div ? ~Funct3E[0] : (Funct3E[1:0] != 2'b11);
    b_sgn  = is_div ? ~Funct3E[0] : ~Funct3E[1];
    a_neg  = a_sgn & src_a[XLEN-1];
    b_neg  = b_sgn & write_data[XLEN-1];
    a_mag  = a_neg ? -src_a : src_a;
    b_mag  = b_neg ? -write_data : write_data;
  end

  // acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, opnd};
    if (op_q[2])
      acc_nxt = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
  end

  always_comb begin
    prod_s = neg_q ? -acc : acc;
    dr     = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    dr_s   = neg_q ? -dr : dr;
    if (op_q[2])
      md_y = div0_q ? (op_q[1] ? dvd_q : '1) : dr_s;
    else
      md_y = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      dvd_q  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (MulDivE) begin
          state  <= MD_BUSY;
          cnt    <= CNT_W'(XLEN);
          op_q   <= Funct3E;
          neg_q  <= (is_div & Funct3E[1]) ? a_neg : (a_neg ^ b_neg);
          div0_q <= (write_data == '0);
          dvd_q  <= src_a;
          opnd   <= is_div ? b_mag : a_mag;
          acc    <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        end
        MD_BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= MD_DONE;
        end
        MD_DONE: state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign StallE     = MulDivE & (state != MD_DONE);
  assign alu_result = (state == MD_DONE) ? md_y : alu_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || StallE) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
      ResultSrcM <= '0;
      MemWriteM  <= 1'b0;
      RegWriteM  <= 1'b0;
    end else begin
      ALUResultM <= alu_result;
      WriteDataM <= write_data;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      RegWriteM  <= RegWriteE;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// tb/tb_execute_stage_md.sv - randomized self-checking bench for execute_stage_md against a
// behavioural reference model.
module tb_execute_stage_md;

  logic        clk, reset;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E, ResultW;
  logic [1:0]  ForwardAE, ForwardBE, ResultSrcE;
  logic [4:0]  RdE;
  logic [2:0]  Funct3E;
  logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, MulDivE;
  logic [3:0]  ALUControlE;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, PCTargetE;
  logic [4:0]  RdM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM, RegWriteM, PCSrcE, StallE;

  int checks = 0;
  int errors = 0;

  // Model view of the EX/MEM register.
  logic [31:0] em_alu, em_wd, em_pc4;
  logic [4:0]  em_rd;
  logic [1:0]  em_rs;
  logic        em_rw, em_mw;

  execute_stage_md #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ResultW(ResultW), .ALUResultM(ALUResultM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .RdE(RdE), .Funct3E(Funct3E),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MulDivE(MulDivE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM),
    .PCTargetE(PCTargetE), .PCSrcE(PCSrcE), .StallE(StallE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rd);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return em_alu;
    return rd;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b);
    case (ctl)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $signed(a) >>> b[4:0];
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    logic        ovf;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'h0, b});
    ua64 = {32'h0, a};
    ub64 = {32'h0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb;     return p[31:0];  end
      3'd1: begin p = sa * sb;     return p[63:32]; end
      3'd2: begin p = sa * ub;     return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic rand_inputs();
    RD1E        = $urandom;
    RD2E        = $urandom;
    ImmExtE     = $urandom;
    PCE         = $urandom;
    PCPlus4E    = $urandom;
    ResultW     = $urandom;
    ForwardAE   = 2'($urandom_range(0, 3));
    ForwardBE   = 2'($urandom_range(0, 3));
    RdE         = 5'($urandom_range(0, 31));
    Funct3E     = 3'($urandom_range(0, 7));
    RegWriteE   = 1'($urandom_range(0, 1));
    MemWriteE   = 1'($urandom_range(0, 1));
    JumpE       = ($urandom_range(0, 7) == 0);
    JalrE       = 1'($urandom_range(0, 1));
    BranchE     = 1'($urandom_range(0, 1));
    ALUSrcE     = 1'($urandom_range(0, 1));
    ResultSrcE  = 2'($urandom_range(0, 3));
    ALUControlE = 4'($urandom_range(0, 15));
    MulDivE     = 1'b0;
  endtask

  task automatic clear_model();
    em_alu = '0; em_wd = '0; em_pc4 = '0; em_rd = '0; em_rs = '0; em_rw = 1'b0; em_mw = 1'b0;
  endtask

  task automatic check_m();
    chk_eq("m_alu_result", ALUResultM, em_alu);
    chk_eq("m_write_data", WriteDataM, em_wd);
    chk_eq("m_pc_plus4", PCPlus4M, em_pc4);
    chk_eq("m_rd", 32'(RdM), 32'(em_rd));
    chk_eq("m_result_src", 32'(ResultSrcM), 32'(em_rs));
    chk_eq("m_reg_write", 32'(RegWriteM), 32'(em_rw));
    chk_eq("m_mem_write", 32'(MemWriteM), 32'(em_mw));
  endtask

  // Single-cycle instruction: inputs are already driven just after a rising edge.
  task automatic alu_step();
    logic [31:0] a, wd, b, res, tgt;
    logic        pcs;
    a   = fwd(ForwardAE, RD1E);
    wd  = fwd(ForwardBE, RD2E);
    b   = ALUSrcE ? ImmExtE : wd;
    res = ref_alu(ALUControlE, a, b);
    pcs = JumpE | (BranchE & ref_taken(Funct3E, a, wd));
    tgt = JalrE ? ((a + ImmExtE) & ~32'd1) : (PCE + ImmExtE);
    #1;
    chk_eq("stall_alu", 32'(StallE), 32'd0);
    chk_eq("pcsrc", 32'(PCSrcE), 32'(pcs));
    chk_eq("pctarget", PCTargetE, tgt);
    @(posedge clk); #1;
    em_alu = res; em_wd = wd; em_pc4 = PCPlus4E; em_rd = RdE;
    em_rs = ResultSrcE; em_rw = RegWriteE; em_mw = MemWriteE;
    check_m();
  endtask

  // Mul/div instruction: counts stall cycles, watches bubbles and redirect gating,
  // and disturbs the forwarded operands part-way through.
  task automatic md_step();
    logic [31:0] exp, wd;
    int          cyc, bad, pcb;
    MulDivE = 1'b1;
    exp   = ref_md(Funct3E, fwd(ForwardAE, RD1E), fwd(ForwardBE, RD2E));
    JumpE = 1'b1;
    cyc = 0; bad = 0; pcb = 0;
    #1;
    while (StallE && cyc < 100) begin
      cyc++;
      if (PCSrcE) pcb++;
      @(posedge clk); #1;
      if (ALUResultM !== 32'd0 || RegWriteM !== 1'b0 || MemWriteM !== 1'b0 || RdM !== 5'd0)
        bad++;
      if (cyc == 5) begin
        RD1E      = $urandom;
        RD2E      = $urandom;
        ResultW   = $urandom;
        ForwardAE = 2'($urandom_range(0, 3));
      end
    end
    if (cyc > 0) clear_model();
    chk_eq("md_stall_cycles", 32'(cyc), 32'd33);
    chk_eq("md_bubbles", 32'(bad), 32'd0);
    chk_eq("md_pcsrc_gated", 32'(pcb), 32'd0);
    wd = fwd(ForwardBE, RD2E);
    @(posedge clk); #1;
    em_alu = exp; em_wd = wd; em_pc4 = PCPlus4E; em_rd = RdE;
    em_rs = ResultSrcE; em_rw = RegWriteE; em_mw = MemWriteE;
    check_m();
  endtask

  task automatic md_directed(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
    rand_inputs();
    Funct3E = f3; ForwardAE = 2'b00; ForwardBE = 2'b00; RD1E = a; RD2E = b;
    md_step();
    chk_eq(tag, ALUResultM, exp);
  endtask

  initial begin
    clear_model();
    rand_inputs();
    reset = 1'b0;
    #12;
    chk_eq("reset_alu_result", ALUResultM, 32'd0);
    chk_eq("reset_reg_write", 32'(RegWriteM), 32'd0);
    chk_eq("reset_stall", 32'(StallE), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    rand_inputs(); ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0; RD1E = 5; RD2E = 7; ALUControlE = 1;
    alu_step();
    chk_eq("tp_sub", ALUResultM, 32'hFFFF_FFFE);
    rand_inputs(); ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0; RD1E = 4; RD2E = 5; ALUControlE = 0;
    alu_step();
    rand_inputs(); ForwardAE = 2'b10; ALUSrcE = 1; ImmExtE = 1; ALUControlE = 0;
    alu_step();
    chk_eq("tp_fwd_m", ALUResultM, 32'd10);

    rand_inputs(); ForwardAE = 0; ForwardBE = 0; RD1E = 32'hFFFF_FFFF; RD2E = 1;
    BranchE = 1; JumpE = 0; JalrE = 0; Funct3E = 3'b100; PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    chk_eq("tp_blt_taken", 32'(PCSrcE), 32'd1);
    chk_eq("tp_blt_target", PCTargetE, 32'h120);
    alu_step();
    rand_inputs(); ForwardAE = 0; ForwardBE = 0; RD1E = 32'hFFFF_FFFF; RD2E = 1;
    BranchE = 1; JumpE = 0; Funct3E = 3'b110;
    #1;
    chk_eq("tp_bltu_not_taken", 32'(PCSrcE), 32'd0);
    alu_step();
    rand_inputs(); ForwardAE = 0; JalrE = 1; RD1E = 32'h1001; ImmExtE = 4;
    #1;
    chk_eq("tp_jalr_target", PCTargetE, 32'h1004);
    alu_step();

    rand_inputs(); ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0; RD1E = 5; RD2E = 7;
    ALUControlE = 1; RegWriteE = 1;
    alu_step();
    reset = 1'b0;
    #1;
    chk_eq("async_rst_alu_result", ALUResultM, 32'd0);
    chk_eq("async_rst_reg_write", 32'(RegWriteM), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_model();

    md_directed("tp_mul", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
    md_directed("tp_mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    md_directed("tp_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_directed("tp_div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    md_directed("tp_rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    md_directed("tp_divu_by0", 3'd5, 32'd12345, 32'd0, 32'hFFFF_FFFF);
    md_directed("tp_rem_by0", 3'd6, 32'd13, 32'd0, 32'd13);
    md_directed("tp_div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    md_directed("tp_div_by0_signed", 3'd4, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);

    rand_inputs(); MulDivE = 1; Funct3E = 3'd4; ForwardAE = 0; ForwardBE = 0; RD2E = 3;
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0; MulDivE = 1'b0;
    #1;
    chk_eq("rst_busy_stall", 32'(StallE), 32'd0);
    chk_eq("rst_busy_alu_result", ALUResultM, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_model();
    md_directed("tp_divu_after_rst", 3'd5, 32'd100, 32'd7, 32'd14);

    repeat (150) begin
      rand_inputs();
      alu_step();
    end
    repeat (30) begin
      rand_inputs();
      if ($urandom_range(0, 5) == 0) begin
        RD2E = 0; ForwardBE = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        RD1E = 32'h8000_0000; RD2E = 32'hFFFF_FFFF; ForwardAE = 0; ForwardBE = 0;
      end
      md_step();
    end
    repeat (60) begin
      rand_inputs();
      if ($urandom_range(0, 4) == 0) md_step();
      else alu_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
